fpu_class_gen: RTL and testbench

Sequential stimulus generator for the floating-point classification path, working in the opposite direction to it. It accepts a request carrying a one-hot class code, in the same 10-bit encoding the classifier produces, plus a beat count. It then emits that many IEEE-754 single-precision values, each guaranteed to belong to the requested class, on a valid/ready stream. It sits in front of the FPU datapath, used by FPU bring-up and BIST to drive class-targeted operands.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_class_shaper.sv | 48 ++++
 rtl/fpu_class_gen.sv | 103 ++++++++++
 tb/tb_fpu_class_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 class codes, field constants and LFSR helpers for the FPU
// classification path and its stimulus generator.
package fpu_pkg;

  // One-hot class codes, same encoding the classifier produces.
  typedef enum logic [9:0] {
    CLS_NEG_INF  = 10'b00_0000_0001,
    CLS_NEG_NORM = 10'b00_0000_0010,
    CLS_NEG_SUB  = 10'b00_0000_0100,
    CLS_NEG_ZERO = 10'b00_0000_1000,
    CLS_POS_ZERO = 10'b00_0001_0000,
    CLS_POS_SUB  = 10'b00_0010_0000,
    CLS_POS_NORM = 10'b00_0100_0000,
    CLS_POS_INF  = 10'b00_1000_0000,
    CLS_SNAN     = 10'b01_0000_0000,
    CLS_QNAN     = 10'b10_0000_0000
  } fp_class_e;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam int          QNAN_BIT  = 22;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic is_onehot10(logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  // Right-shift Galois step.
  function automatic logic [31:0] lfsr_next(logic [31:0] r);
    return {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/fpu_class_shaper.sv
// Combinational mapping of (one-hot class, random word) to an FP32 value that
// is guaranteed to belong to that class; an all-zero class yields 0.
module fpu_class_shaper
  import fpu_pkg::*;
(
  input  logic [9:0]  cls,
  input  logic [31:0] r,
  output logic [31:0] value
);

  logic [7:0]  norm_exp;
  logic [22:0] sub_man;
  logic [22:0] snan_man;
  logic [22:0] qnan_man;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    norm_exp = r[30:23];
    value    = 32'd0;

    // Keep normals off the zero/subnormal and inf/NaN exponent codes.
    if (norm_exp == 8'h00) begin
      norm_exp = 8'h01;
    end else if (norm_exp == EXP_MAX) begin
      norm_exp = EXP_MAX - 8'd1;
    end

    sub_man  = (r[22:0] == 23'd0) ? 23'd1 : r[22:0];
    qnan_man = {1'b1, r[QNAN_BIT-1:0]};
    snan_man = (r[QNAN_BIT-1:0] == 22'd0) ? 23'd1 : {1'b0, r[QNAN_BIT-1:0]};

    case (cls)
      CLS_NEG_INF:  value = {1'b1, EXP_MAX, 23'd0};
      CLS_NEG_NORM: value = {1'b1, norm_exp, r[22:0]};
      CLS_NEG_SUB:  value = {1'b1, 8'h00, sub_man};
      CLS_NEG_ZERO: value = {1'b1, 31'd0};
      CLS_POS_ZERO: value = 32'd0;
      CLS_POS_SUB:  value = {1'b0, 8'h00, sub_man};
      CLS_POS_NORM: value = {1'b0, norm_exp, r[22:0]};
      CLS_POS_INF:  value = {1'b0, EXP_MAX, 23'd0};
      CLS_SNAN:     value = {r[31], EXP_MAX, snan_man};
      CLS_QNAN:     value = {r[31], EXP_MAX, qnan_man};
      default:      value = 32'd0;
    endcase
  end

endmodule

// File: rtl/fpu_class_gen.sv
// Class-targeted FP32 stimulus generator: accepts {class, count} requests and
// emits count values of that class on a valid/ready stream.
module fpu_class_gen
  import fpu_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_class,
  input  logic [CNT_W-1:0] req_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [9:0]       out_class,
  output logic             out_last,
  output logic             err
);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       class_q, class_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             err_q, err_d;
  logic             emit;
  logic [31:0]      shaped;

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    remaining_d = remaining_q;
    lfsr_d      = lfsr_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Illegal class and zero count are both consumed without emitting.
        if (req_valid) begin
          if (!is_onehot10(req_class)) begin
            err_d = 1'b1;
          end else if (req_count != '0) begin
            state_d     = S_EMIT;
            class_d     = req_class;
            remaining_d = req_count;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          lfsr_d      = lfsr_next(lfsr_q);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            class_d = 10'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      class_q     <= 10'd0;
      remaining_q <= '0;
      lfsr_q      <= LFSR_SEED;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      remaining_q <= remaining_d;
      lfsr_q      <= lfsr_d;
      err_q       <= err_d;
    end
  end

  fpu_class_shaper u_shaper (
    .cls   (class_q),
    .r     (lfsr_q),
    .value (shaped)
  );

  // Outputs depend only on registered state.
  assign emit      = (state_q == S_EMIT);
  assign req_ready = !emit;
  assign out_valid = emit;
  assign out_data  = emit ? shaped : 32'd0;
  assign out_class = emit ? class_q : 10'd0;
  assign out_last  = emit && (remaining_q == CNT_W'(1));
  assign err       = err_q;

endmodule

// File: tb/tb_fpu_class_gen.sv
// Scoreboard bench for fpu_class_gen: stimulus pushes expected beats, a
// negedge monitor pops and compares on every output handshake.
module tb_fpu_class_gen;
  import fpu_pkg::*;

  localparam int          CNT_W = 8;
  localparam logic [31:0] SEED  = 32'h0000_0001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [9:0]       req_class = 10'd0;
  logic [CNT_W-1:0] req_count = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [9:0]       out_class;
  logic             out_last;
  logic             err;

  fpu_class_gen #(.LFSR_SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .req_count (req_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [9:0]  cls;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          hs_count = 0;
  int          stall_mode = 0;
  int          stall_phase = 0;
  logic [31:0] model_r = SEED;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  function automatic logic [31:0] tb_lfsr(input logic [31:0] r);
    logic [31:0] n;
    n = r >> 1;
    if (r[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [31:0] tb_shape(input logic [9:0] c, input logic [31:0] r);
    logic [7:0]  e;
    logic [22:0] m;
    logic [22:0] sm;
    e = r[30:23];
    m = r[22:0];
    if (e == 8'h00) e = 8'h01;
    if (e == 8'hFF) e = 8'hFE;
    sm = (m == 23'd0) ? 23'd1 : m;
    case (c)
      10'h001: return 32'hFF80_0000;
      10'h002: return {1'b1, e, m};
      10'h004: return {1'b1, 8'h00, sm};
      10'h008: return 32'h8000_0000;
      10'h010: return 32'h0000_0000;
      10'h020: return {1'b0, 8'h00, sm};
      10'h040: return {1'b0, e, m};
      10'h080: return 32'h7F80_0000;
      10'h100: return {r[31], 8'hFF, (r[21:0] == 22'd0) ? 23'd1 : {1'b0, r[21:0]}};
      default: return {r[31], 8'hFF, 1'b1, r[21:0]};
    endcase
  endfunction

  function automatic logic [9:0] classify(input logic [31:0] v);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = v[31];
    e = v[30:23];
    m = v[22:0];
    if (e == 8'hFF) begin
      if (m == 23'd0) return s ? 10'h001 : 10'h080;
      return m[22] ? 10'h200 : 10'h100;
    end
    if (e == 8'h00) begin
      if (m == 23'd0) return s ? 10'h008 : 10'h010;
      return s ? 10'h004 : 10'h020;
    end
    return s ? 10'h002 : 10'h040;
  endfunction

  // Consumer: always ready, repeating 1-0-0, or random.
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (stall_phase % 3 == 0);
        stall_phase++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [42:0] held;
  logic        held_v = 1'b0;
  beat_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) check("stall_stable", 64'({out_data, out_class, out_last}), 64'(held));
      if (out_ready) begin
        hs_count++;
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(mon_e.data));
          check("beat_class", 64'(out_class), 64'(mon_e.cls));
          check("beat_last", 64'(out_last), 64'(mon_e.last));
        end
        check("classifier", 64'(classify(out_data)), 64'(out_class));
      end else begin
        held_v = 1'b1;
        held   = {out_data, out_class, out_last};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    model_r = SEED;
  endtask

  task automatic push_hand(input logic [31:0] d, input logic [9:0] c, input logic l);
    exp_q.push_back('{data: d, cls: c, last: l});
    model_r = tb_lfsr(model_r);
  endtask

  task automatic push_model(input logic [9:0] c, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back('{data: tb_shape(c, model_r), cls: c, last: (i == cnt - 1)});
      model_r = tb_lfsr(model_r);
    end
  endtask

  // Entered and left at posedge+1; the request is accepted at the edge in between.
  task automatic send_req(input logic [9:0] c, input int cnt);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("req_ready_timeout", 64'(n), 64'd0);
    req_valid = 1'b1;
    req_class = c;
    req_count = CNT_W'(cnt);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && req_ready) && n < 500) begin
      tick();
      n++;
    end
    check("drain_done", 64'(n >= 500), 64'd0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_err",       64'(err),       64'd0);
    tick();

    // +normal x2 from the seed: r=1 then r=8020_0003.
    push_hand(32'h0080_0001, CLS_POS_NORM, 1'b0);
    push_hand(32'h00A0_0003, CLS_POS_NORM, 1'b1);
    send_req(CLS_POS_NORM, 2);
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_req_ready", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    check("t2_out_last", 64'(out_last), 64'd1);
    tick();
    @(negedge clk);
    check("t3_req_ready", 64'(req_ready), 64'd1);
    check("t3_out_valid", 64'(out_valid), 64'd0);
    tick();

    // Fresh reset; r runs 1, 8020_0003, C030_0002, 6018_0001.
    do_reset();
    push_hand(32'h0000_0000, CLS_POS_ZERO, 1'b1);
    send_req(CLS_POS_ZERO, 1);
    drain();
    push_hand(32'hFF80_0000, CLS_NEG_INF, 1'b1);
    send_req(CLS_NEG_INF, 1);
    drain();
    push_hand(32'hFFF0_0002, CLS_QNAN, 1'b1);
    send_req(CLS_QNAN, 1);
    drain();
    push_hand(32'h7F98_0001, CLS_SNAN, 1'b1);
    send_req(CLS_SNAN, 1);
    drain();

    // Two-hot class: consumed, err pulse, nothing emitted.
    send_req(10'b00_0000_0011, 1);
    @(negedge clk);
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_no_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("illegal_err_drop", 64'(err), 64'd0);
    check("illegal_no_valid2", 64'(out_valid), 64'd0);
    check("illegal_ready", 64'(req_ready), 64'd1);
    tick();

    // Zero count with a legal class: silent.
    send_req(CLS_POS_INF, 0);
    @(negedge clk);
    check("zero_cnt_err", 64'(err), 64'd0);
    check("zero_cnt_valid", 64'(out_valid), 64'd0);
    tick();

    // -subnormal x3 under stalls; LFSR untouched by the rejected requests,
    // so r = B02C_0003, D836_0002, 6C1B_0001.
    stall_phase = 0;
    stall_mode  = 1;
    hs_count    = 0;
    push_hand(32'h802C_0003, CLS_NEG_SUB, 1'b0);
    push_hand(32'h8036_0002, CLS_NEG_SUB, 1'b0);
    push_hand(32'h801B_0001, CLS_NEG_SUB, 1'b1);
    send_req(CLS_NEG_SUB, 3);
    drain();
    check("sub_handshakes", 64'(hs_count), 64'd3);
    stall_mode = 0;
    tick();

    // Reset after the first of four beats.
    push_model(CLS_POS_NORM, 4);
    send_req(CLS_POS_NORM, 4);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    exp_q.delete();
    model_r = SEED;
    tick();
    push_hand(32'h0080_0001, CLS_POS_NORM, 1'b0);
    push_hand(32'h00A0_0003, CLS_POS_NORM, 1'b1);
    send_req(CLS_POS_NORM, 2);
    drain();

    // Random legal requests under random backpressure.
    stall_mode = 2;
    for (int k = 0; k < 12; k++) begin
      logic [9:0] c;
      int         cnt;
      c   = 10'd1 << $urandom_range(0, 9);
      cnt = $urandom_range(1, 5);
      push_model(c, cnt);
      send_req(c, cnt);
      drain();
    end
    stall_mode = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
